// File: rtl/rv32i_run_ctrl_pkg.sv
// Shared types and constants for the RV32I run-control block.
package rv32i_dbg_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } run_state_e;

  localparam logic [2:0] CAUSE_NONE = 3'd0;
  localparam logic [2:0] CAUSE_HLT  = 3'd1;
  localparam logic [2:0] CAUSE_BP   = 3'd2;
  localparam logic [2:0] CAUSE_DBG  = 3'd3;
  localparam logic [2:0] CAUSE_STEP = 3'd4;

  // Halt cause when leaving RUN: HLT beats breakpoint beats debugger.
  function automatic logic [2:0] run_halt_cause(input logic hlt, input logic bp,
                                                input logic dbg);
    if (hlt)     return CAUSE_HLT;
    else if (bp) return CAUSE_BP;
    else if (dbg) return CAUSE_DBG;
    else         return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/rv32i_run_ctrl_if.sv
// Debug-side port of the run-control unit: requests, breakpoint writes, status.
interface rv32i_run_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int NUM_BP = 2
) ();
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

  logic             dbg_halt_req;
  logic             dbg_resume_req;
  logic             dbg_step_req;
  logic             bp_wr_en;
  logic [IDX_W-1:0] bp_wr_idx;
  logic [XLEN-1:0]  bp_wr_addr;
  logic             bp_wr_valid;
  logic             halted;
  logic [2:0]       halt_cause;
  logic             step_done;

  // Debugger side drives requests and breakpoint writes, observes status.
  modport master (
    output dbg_halt_req, dbg_resume_req, dbg_step_req,
    output bp_wr_en, bp_wr_idx, bp_wr_addr, bp_wr_valid,
    input  halted, halt_cause, step_done
  );

  // Run-control side.
  modport slave (
    input  dbg_halt_req, dbg_resume_req, dbg_step_req,
    input  bp_wr_en, bp_wr_idx, bp_wr_addr, bp_wr_valid,
    output halted, halt_cause, step_done
  );
endinterface

// File: rtl/rv32i_run_ctrl_bp_unit.sv
// PC breakpoint slots: address/valid registers, write port and match OR-tree.
module rv32i_bp_unit #(
  parameter int XLEN   = 32,
  parameter int NUM_BP = 2,
  parameter int IDX_W  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [XLEN-1:0]  wr_addr,
  input  logic             wr_valid,
  input  logic [XLEN-1:0]  pc,
  output logic             bp_hit
);
  // Only word-aligned address bits are compared, so the byte offset is not stored.
  logic [NUM_BP-1:0][XLEN-3:0] bp_addr;
  logic [NUM_BP-1:0]           bp_valid;
  logic [NUM_BP-1:0]           slot_hit;

  logic unused_lsb;
  assign unused_lsb = ^{wr_addr[1:0], pc[1:0]};

  // Slot write port; an index beyond NUM_BP writes nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_valid <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          bp_addr[i]  <= wr_addr[XLEN-1:2];
          bp_valid[i] <= wr_valid;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_BP; i++) begin : g_slot
    assign slot_hit[i] = bp_valid[i] && (bp_addr[i] == pc[XLEN-1:2]);
  end

  assign bp_hit = |slot_hit;

endmodule

// File: rtl/rv32i_run_ctrl.sv
// Run control for the RV32I single-cycle core: clock-enable based halt,
// debug halt/resume/step, PC breakpoints and cycle/instret counters.
module rv32i_run_ctrl
  import rv32i_dbg_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_BP       = 2,
  parameter int CNT_W        = 32,
  parameter int START_HALTED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hlt_in,
  input  logic [XLEN-1:0]       pc,
  rv32i_run_ctrl_if.slave       dbg,
  output logic                  core_en,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      instret_cnt
);
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

  run_state_e state;
  logic       halted_q;
  logic [2:0] cause_q;
  logic       step_done_q;
  logic       skip_bp;
  logic       bp_hit;
  logic       bp_eff;
  logic       halt_cond;

  rv32i_bp_unit #(
    .XLEN   (XLEN),
    .NUM_BP (NUM_BP),
    .IDX_W  (IDX_W)
  ) u_bp (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (dbg.bp_wr_en),
    .wr_idx   (dbg.bp_wr_idx),
    .wr_addr  (dbg.bp_wr_addr),
    .wr_valid (dbg.bp_wr_valid),
    .pc       (pc),
    .bp_hit   (bp_hit)
  );

  // A resumed breakpoint is masked for one RUN cycle so its instruction retires.
  assign bp_eff    = bp_hit & ~skip_bp;
  assign halt_cond = hlt_in | bp_eff | dbg.dbg_halt_req;

  // Enable is decided in the same cycle so a halting instruction never executes.
  always_comb begin
    core_en = 1'b0;
    if (!rst) begin
      case (state)
        RUN:     core_en = ~halt_cond;
        STEP:    core_en = ~hlt_in;
        default: core_en = 1'b0;
      endcase
    end
  end

  // Run-state machine with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= (START_HALTED != 0) ? HALTED : RUN;
      halted_q    <= (START_HALTED != 0);
      cause_q     <= CAUSE_NONE;
      step_done_q <= 1'b0;
      skip_bp     <= 1'b0;
    end else begin
      step_done_q <= 1'b0;
      case (state)
        RUN: begin
          skip_bp <= 1'b0;
          if (halt_cond) begin
            state    <= HALTED;
            halted_q <= 1'b1;
            cause_q  <= run_halt_cause(hlt_in, bp_eff, dbg.dbg_halt_req);
          end
        end
        HALTED: begin
          // A HLT instruction is terminal until reset.
          if (cause_q != CAUSE_HLT) begin
            if (dbg.dbg_step_req) begin
              state    <= STEP;
              halted_q <= 1'b0;
            end else if (dbg.dbg_resume_req) begin
              state    <= RUN;
              halted_q <= 1'b0;
              skip_bp  <= 1'b1;
              cause_q  <= CAUSE_NONE;
            end
          end
        end
        STEP: begin
          state    <= HALTED;
          halted_q <= 1'b1;
          if (hlt_in) begin
            cause_q <= CAUSE_HLT;
          end else begin
            cause_q     <= CAUSE_STEP;
            step_done_q <= 1'b1;
          end
        end
        default: begin
          state    <= HALTED;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  // Free-running cycle counter and retired-instruction counter, both wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (core_en) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

  assign dbg.halted     = halted_q;
  assign dbg.halt_cause = cause_q;
  assign dbg.step_done  = step_done_q;

endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Directed plus randomized bench for rv32i_run_ctrl against a rule-level model.
module tb_rv32i_run_ctrl;
  localparam int XLEN   = 32;
  localparam int NUM_BP = 2;
  localparam int CNT_W  = 4;
  localparam int CMOD   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             hlt_in;
  logic [XLEN-1:0]  pc;
  logic             core_en;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  rv32i_run_ctrl_if #(.XLEN(XLEN), .NUM_BP(NUM_BP)) dbg ();

  rv32i_run_ctrl #(
    .XLEN(XLEN), .NUM_BP(NUM_BP), .CNT_W(CNT_W), .START_HALTED(0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hlt_in      (hlt_in),
    .pc          (pc),
    .dbg         (dbg),
    .core_en     (core_en),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  // Model: "halted", "stepping" flags plus the spec's bookkeeping values.
  bit          m_halted, m_stepping, m_skip, m_sd;
  int          m_cause, m_cyc, m_ir;
  logic [31:0] m_bpa [NUM_BP];
  bit          m_bpv [NUM_BP];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        last_en;
  int          saved;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit();
    bit h = 0;
    for (int i = 0; i < NUM_BP; i++)
      if (m_bpv[i] && (m_bpa[i] >> 2) == (pc >> 2)) h = 1;
    return h;
  endfunction

  function automatic bit m_en();
    if (rst) return 0;
    if (m_stepping) return !hlt_in;
    if (m_halted) return 0;
    return !(hlt_in || (m_hit() && !m_skip) || dbg.dbg_halt_req);
  endfunction

  task automatic idle();
    hlt_in = 0;
    dbg.dbg_halt_req = 0; dbg.dbg_resume_req = 0; dbg.dbg_step_req = 0;
    dbg.bp_wr_en = 0; dbg.bp_wr_idx = '0; dbg.bp_wr_addr = '0; dbg.bp_wr_valid = 0;
  endtask

  // One clock: check core_en with current inputs, advance model, check registered outputs.
  task automatic tick();
    bit en, hit_eff;
    #1;
    en = m_en();
    last_en = core_en;
    chk("core_en", core_en, en);
    if (rst) begin
      m_halted = 0; m_stepping = 0; m_skip = 0; m_sd = 0;
      m_cause = 0; m_cyc = 0; m_ir = 0;
      for (int i = 0; i < NUM_BP; i++) m_bpv[i] = 0;
    end else begin
      hit_eff = m_hit() && !m_skip;
      m_cyc = (m_cyc + 1) % CMOD;
      m_ir  = (m_ir + int'(en)) % CMOD;
      m_sd  = 0;
      if (m_stepping) begin
        m_stepping = 0; m_halted = 1;
        if (hlt_in) m_cause = 1;
        else begin m_cause = 4; m_sd = 1; end
      end else if (m_halted) begin
        if (m_cause != 1) begin
          if (dbg.dbg_step_req) begin m_stepping = 1; m_halted = 0; end
          else if (dbg.dbg_resume_req) begin m_halted = 0; m_skip = 1; m_cause = 0; end
        end
      end else begin
        m_skip = 0;
        if (hlt_in) begin m_halted = 1; m_cause = 1; end
        else if (hit_eff) begin m_halted = 1; m_cause = 2; end
        else if (dbg.dbg_halt_req) begin m_halted = 1; m_cause = 3; end
      end
      if (dbg.bp_wr_en && int'(dbg.bp_wr_idx) < NUM_BP) begin
        m_bpa[dbg.bp_wr_idx] = dbg.bp_wr_addr;
        m_bpv[dbg.bp_wr_idx] = dbg.bp_wr_valid;
      end
    end
    @(posedge clk);
    #1;
    chk("halted", dbg.halted, m_halted);
    chk("halt_cause", dbg.halt_cause, m_cause);
    chk("step_done", dbg.step_done, m_sd);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("instret_cnt", instret_cnt, m_ir);
  endtask

  task automatic bp_write(input int idx, input logic [31:0] addr, input bit v);
    dbg.bp_wr_en = 1; dbg.bp_wr_idx = idx[0:0]; dbg.bp_wr_addr = addr; dbg.bp_wr_valid = v;
    tick();
    dbg.bp_wr_en = 0;
  endtask

  initial begin
    idle(); pc = '0;
    // Reset and free run
    rst = 1; tick(); rst = 0;
    chk("rst_halted", dbg.halted, 0);
    chk("rst_cause", dbg.halt_cause, 0);
    chk("rst_instret", instret_cnt, 0);
    for (int i = 0; i < 10; i++) begin pc = 32'(i * 4); tick(); end
    chk("free_cycle", cycle_cnt, 10);
    chk("free_instret", instret_cnt, 10);

    // Breakpoint, resume with skip, re-halt
    pc = 32'h0; bp_write(0, 32'h10, 1);
    pc = 32'h10; tick();
    chk("bp_en", last_en, 0);
    chk("bp_halted", dbg.halted, 1);
    chk("bp_cause", dbg.halt_cause, 2);
    dbg.dbg_resume_req = 1; tick(); dbg.dbg_resume_req = 0;
    tick(); chk("skip_en", last_en, 1);
    tick(); chk("rehalt_en", last_en, 0);
    chk("rehalt_cause", dbg.halt_cause, 2);

    // Single step
    saved = int'(instret_cnt);
    dbg.dbg_step_req = 1; tick(); dbg.dbg_step_req = 0;
    tick(); chk("step_en", last_en, 1);
    chk("step_done", dbg.step_done, 1);
    chk("step_cause", dbg.halt_cause, 4);
    chk("step_instret", instret_cnt, (saved + 1) % CMOD);
    tick(); chk("step_done_clr", dbg.step_done, 0);

    // Step and resume together: step wins
    dbg.dbg_step_req = 1; dbg.dbg_resume_req = 1; tick(); idle();
    tick(); chk("sr_en", last_en, 1);
    chk("sr_halted", dbg.halted, 1);

    // Debugger halt
    dbg.dbg_resume_req = 1; tick(); idle();
    pc = 32'h40; tick();
    dbg.dbg_halt_req = 1; tick(); idle();
    chk("dbg_cause", dbg.halt_cause, 3);

    // Reset during STEP: no step_done
    dbg.dbg_step_req = 1; tick(); idle();
    rst = 1; tick(); rst = 0;
    chk("rst_step_done", dbg.step_done, 0);
    chk("rst_step_halted", dbg.halted, 0);

    // HLT is terminal until reset
    pc = 32'h80; hlt_in = 1; tick(); hlt_in = 0;
    chk("hlt_cause", dbg.halt_cause, 1);
    saved = int'(instret_cnt);
    for (int i = 0; i < 5; i++) begin
      dbg.dbg_resume_req = i[0]; dbg.dbg_step_req = ~i[0]; tick();
      chk("hlt_stay", dbg.halted, 1);
    end
    idle();
    chk("hlt_instret", instret_cnt, saved);
    rst = 1; tick(); rst = 0;
    chk("hlt_rst_cause", dbg.halt_cause, 0);
    chk("hlt_rst_halted", dbg.halted, 0);

    // Priority: HLT over breakpoint over debug
    pc = 32'h0; bp_write(1, 32'h20, 1);
    pc = 32'h22; hlt_in = 1; dbg.dbg_halt_req = 1; tick(); idle();
    chk("prio_cause", dbg.halt_cause, 1);

    // instret wrap at 2^CNT_W
    rst = 1; tick(); rst = 0;
    pc = 32'h100;
    for (int i = 0; i < 16; i++) tick();
    chk("wrap_instret", instret_cnt, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      hlt_in = ($urandom_range(0, 39) == 0);
      dbg.dbg_halt_req   = ($urandom_range(0, 15) == 0);
      dbg.dbg_resume_req = ($urandom_range(0, 3) == 0);
      dbg.dbg_step_req   = ($urandom_range(0, 7) == 0);
      dbg.bp_wr_en       = ($urandom_range(0, 9) == 0);
      dbg.bp_wr_idx      = 1'($urandom_range(0, 1));
      dbg.bp_wr_addr     = 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      dbg.bp_wr_valid    = ($urandom_range(0, 3) != 0);
      pc = 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      tick();
    end
    rst = 0; idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_run_ctrl.md
Name: rv32i_run_ctrl

Overview:
Parametrised run-control unit for the RV32I single-cycle core. It replaces the clock-gating halt block with a clock-enable scheme. It adds:
- debug halt, resume and single-step;
- NUM_BP PC breakpoints;
- cycle and retired-instruction counters.

It sits between the controller's halt decode and the datapath. The datapath and register file advance only on cycles where core_en=1.

Parameters:
XLEN, 32, width of pc and breakpoint address registers
NUM_BP, 2, number of PC breakpoint comparators (1..8)
CNT_W, 32, width of cycle_cnt and instret_cnt
START_HALTED, 0, 1 = leave reset in HALTED instead of RUN

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous, active-high reset
hlt_in  in  1  controller decoded a halt instruction at current pc
pc  in  XLEN  current program counter from datapath
dbg_halt_req  in  1  debugger halt request (level, sampled each cycle)
dbg_resume_req  in  1  debugger resume request
dbg_step_req  in  1  debugger single-step request
bp_wr_en  in  1  write breakpoint slot
bp_wr_idx  in  $clog2(NUM_BP) (min 1)  slot index
bp_wr_addr  in  XLEN  breakpoint address
bp_wr_valid  in  1  valid bit written with slot (0 = disable)
core_en  out  1  datapath/regfile/PC update enable (combinational from state and inputs)
halted  out  1  state==HALTED (registered)
halt_cause  out  3  0 none, 1 HLT instr, 2 breakpoint, 3 debug, 4 step
step_done  out  1  one-cycle pulse on STEP->HALTED
cycle_cnt  out  CNT_W  cycles since reset
instret_cnt  out  CNT_W  cycles with core_en=1

Behaviour:
- Reset (rst=1 at posedge):
  - state=RUN, or HALTED if START_HALTED=1;
  - halt_cause=0, step_done=0, counters=0, all bp valid bits=0, skip_bp=0;
  - core_en=0 while rst is high.
- States:
  - RUN: executing.
  - HALTED: frozen.
  - STEP: exactly one enabled cycle, then HALTED.
- Breakpoint match: bp_hit = OR over slots of (valid[i] && bp_addr[i][XLEN-1:2]==pc[XLEN-1:2]).
  - Slot writes occur in any state and take effect the following cycle.
- RUN:
  - halt_cond = hlt_in | (bp_hit & ~skip_bp) | dbg_halt_req.
  - If halt_cond: core_en=0 that cycle, so the instruction at pc is not executed. Next state HALTED. halt_cause priority: HLT(1) > breakpoint(2) > debug(3).
  - Otherwise core_en=1.
  - skip_bp clears after any RUN cycle.
- HALTED:
  - core_en=0.
  - If halt_cause==1, resume and step are ignored; only rst exits.
  - Otherwise dbg_step_req -> STEP. Step wins if step and resume are asserted together.
  - Otherwise dbg_resume_req -> RUN with skip_bp=1, so the instruction at the breakpointed pc executes once.
  - dbg_halt_req is ignored.
- STEP:
  - Breakpoints are ignored.
  - If hlt_in: core_en=0, next HALTED, cause=1, no step_done.
  - Otherwise: core_en=1 for this one cycle, next HALTED, cause=4, step_done=1 in the following cycle.
- halt_cause holds its value while HALTED and resets to 0 on entry to RUN.
- cycle_cnt increments on every non-reset cycle and wraps modulo 2^CNT_W.
- instret_cnt increments on each cycle with core_en=1 and wraps modulo 2^CNT_W.
- rst mid-step or mid-halt: reset values win in the same edge; no step_done is emitted.

Decomposition:
- Package rv32i_dbg_pkg holds:
  - state enum {RUN, HALTED, STEP};
  - halt_cause localparams CAUSE_NONE=0, CAUSE_HLT=1, CAUSE_BP=2, CAUSE_DBG=3, CAUSE_STEP=4.
- One sub-module, rv32i_bp_unit, holds the NUM_BP address/valid registers, the write port and the comparator OR-tree. It outputs bp_hit.

Test Plan:
- Free run: rst 1 cycle, no requests, 10 cycles -> core_en=1 each cycle; cycle_cnt=10, instret_cnt=10; halted=0.
- Breakpoint and resume:
  - Set slot0=0x0000_0010 (valid), drive pc=0x10 -> core_en=0, next cycle halted=1, cause=2.
  - Resume -> core_en=1 with pc=0x10 (skip).
  - pc still 0x10 on the next cycle -> halts again.
- Single step: in HALTED pulse dbg_step_req -> exactly one core_en=1 cycle; instret_cnt +1; step_done pulses 1 cycle; cause=4.
- Simultaneous step+resume in HALTED -> STEP taken (one enabled cycle, then halted).
- HLT terminal: hlt_in=1 in RUN -> cause=1.
  - Resume/step ignored for 5 cycles (halted stays 1, instret frozen).
  - rst -> RUN, cause=0.
- Priority and wrap:
  - hlt_in, bp_hit and dbg_halt_req together -> cause=1.
  - With CNT_W=4, after 16 enabled cycles instret_cnt=0.
